// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue, one outstanding imem request, optional IFETCH_QUEUE_BYPASS_EN
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   instr_valid,
  output logic [31:0]            instr,
  output logic [31:0]            instr_pc,
  input  logic                   instr_ready,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [31:0]   RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DROP = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, rem;
  logic [31:0]   instr_q, instr_d, ipc_q, ipc_d;
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];
  logic          ack_keep, bypass_hit, head_valid, take, pop, push;

  // Only a response to a live (non-dropped) request that is not overtaken by a redirect is kept.
  assign ack_keep   = (state_q == S_REQ) && imem_ack && !redirect;
  assign head_valid = (count_q != '0);
  assign imem_req   = (state_q != S_IDLE);
  assign imem_addr  = addr_q;
  assign q_count    = count_q;

`ifdef IFETCH_QUEUE_BYPASS_EN
  assign bypass_hit  = ack_keep && !head_valid;
  assign instr_valid = head_valid || bypass_hit;
  assign instr       = bypass_hit ? imem_rdata : instr_q;
  assign instr_pc    = bypass_hit ? addr_q : ipc_q;
`else
  assign bypass_hit  = 1'b0;
  assign instr_valid = head_valid;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
`endif

  // A redirect wins over a same-cycle pop; a bypassed word that is consumed never enters the queue.
  assign take = instr_valid && instr_ready && !redirect;
  assign pop  = take && head_valid;
  assign push = ack_keep && !(bypass_hit && take);
  assign rem  = count_q - CW'(pop);

  // Queue occupancy and pointer bookkeeping; a redirect empties the queue.
  always_comb begin
    count_d = count_q;
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    if (redirect) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  // Head entry registers: load the new head after a pop/push, otherwise hold the last values.
  always_comb begin
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (!redirect) begin
      if (rem != '0) begin
        instr_d = mem_data_q[head_d];
        ipc_d   = mem_pc_q[head_d];
      end else if (push) begin
        instr_d = imem_rdata;
        ipc_d   = addr_q;
      end
    end
  end

  // Fetch FSM next state; the space check counts the request about to be issued.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      S_IDLE: if (count_q < FULL) state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_d < FULL) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: if (imem_ack) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      state_d    = ((state_q != S_IDLE) && !imem_ack) ? S_DROP : S_REQ;
    end
    // A dropped request keeps its address on the bus until its response arrives.
    addr_d = (state_d == S_REQ) ? fetch_pc_d : addr_q;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_ADDR;
      addr_q     <= RESET_ADDR;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      instr_q    <= '0;
      ipc_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
    end
  end

  // Queue storage; entries are only read while counted valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[tail_q] <= imem_rdata;
      mem_pc_q[tail_q]   <= addr_q;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue
module tb_ifetch_queue;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_ack = 1'b0, redirect = 1'b0, instr_valid, instr_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0, instr, instr_pc;
  logic [2:0]  q_count;

  int          compared = 0, mismatched = 0;
  logic [63:0] sb [$];
  logic [31:0] exp_pc = '0, drop_addr = '0, force_val = '0;
  bit          dropping = 1'b0, ack_en = 1'b0, force_data = 1'b0;

  always #5 clk = ~clk;

  ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .q_count(q_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    exp_pc    = 32'h0;
    dropping  = 1'b0;
    drop_addr = 32'h0;
  endtask

  // Called at a falling edge: check outputs against the scoreboard, drive memory, update model, advance.
  task automatic cycle();
    logic [31:0] exp_data;
    check("q_count", 32'(q_count), 32'(sb.size()));
    check("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("instr", instr, sb[0][63:32]);
      check("instr_pc", instr_pc, sb[0][31:0]);
    end
    if (imem_req) check("imem_addr", imem_addr, dropping ? drop_addr : exp_pc);
    imem_ack   = ack_en && imem_req;
    imem_rdata = force_data ? force_val : mem_word(imem_addr);
    exp_data   = force_data ? force_val : mem_word(exp_pc);
    if (redirect) begin
      sb.delete();
      if (imem_req && !imem_ack && !dropping) drop_addr = exp_pc;
      dropping = imem_req && !imem_ack;
      exp_pc   = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (sb.size() != 0 && instr_ready) void'(sb.pop_front());
      if (imem_ack) begin
        if (dropping) begin
          dropping = 1'b0;
        end else begin
          sb.push_back({exp_data, exp_pc});
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b0;
    imem_ack = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_count", 32'(q_count), 32'd0);

    // Streaming: ack every request, consume every instruction
    reset = 1'b1; ack_en = 1'b1; instr_ready = 1'b1;
    repeat (8) begin
      cycle();
      check("stream_cnt_le1", 32'(q_count <= 3'd1), 32'd1);
    end

    // Fill with consumer stalled, then one pop refills at 0x10
    apply_reset();
    ack_en = 1'b1; instr_ready = 1'b0;
    repeat (8) cycle();
    check("full_count", 32'(q_count), 32'd4);
    check("full_req", 32'(imem_req), 32'd0);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0; ack_en = 1'b0;
    cycle();
    check("refill_req", 32'(imem_req), 32'd1);
    check("refill_addr", imem_addr, 32'h10);

    // Redirect while request to 0x8 is outstanding -> drop its response
    apply_reset();
    ack_en = 1'b1; instr_ready = 1'b0;
    repeat (3) cycle();
    ack_en = 1'b0;
    cycle();
    check("pre_redir_addr", imem_addr, 32'h8);
    redirect = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_addr", imem_addr, 32'h8);
    check("drop_count", 32'(q_count), 32'd0);
    ack_en = 1'b1; force_data = 1'b1; force_val = 32'hDEAD_BEEF;
    cycle();
    force_data = 1'b0; ack_en = 1'b0;
    check("after_drop_addr", imem_addr, 32'h100);
    check("after_drop_count", 32'(q_count), 32'd0);
    ack_en = 1'b1;
    cycle();
    ack_en = 1'b0;
    check("first_pc_after_redir", instr_pc, 32'h100);
    check("first_instr_after_redir", instr, mem_word(32'h100));

    // Redirect to unaligned 0x203 in the same cycle as an ack
    redirect = 1'b1; redirect_pc = 32'h203; ack_en = 1'b1;
    cycle();
    redirect = 1'b0; ack_en = 1'b0;
    check("redir_ack_count", 32'(q_count), 32'd0);
    check("redir_ack_valid", 32'(instr_valid), 32'd0);
    check("redir_ack_req", 32'(imem_req), 32'd1);
    check("redir_ack_addr", imem_addr, 32'h200);

    // Full queue with simultaneous pop and redirect
    ack_en = 1'b1;
    repeat (6) cycle();
    check("full2_count", 32'(q_count), 32'd4);
    ack_en = 1'b0; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    cycle();
    redirect = 1'b0; instr_ready = 1'b0;
    check("pop_redir_count", 32'(q_count), 32'd0);
    check("pop_redir_valid", 32'(instr_valid), 32'd0);
    check("pop_redir_hold_pc", instr_pc, 32'h200);
    check("pop_redir_addr", imem_addr, 32'h40);

    // Asynchronous reset mid-request, stale ack ignored, restart at RESET_PC
    check("pre_async_req", 32'(imem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_count", 32'(q_count), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    check("post_rst_count", 32'(q_count), 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    ack_en = 1'b1; instr_ready = 1'b1;
    repeat (5) cycle();
    ack_en = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
